// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the burst-writer state type.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    WR_IDLE      = 3'd0,
    WR_WAIT_DATA = 3'd1,
    WR_ADDR      = 3'd2,
    WR_DATA      = 3'd3,
    WR_RESP      = 3'd4,
    WR_DONE      = 3'd5
  } wr_state_e;

endpackage

// File: rtl/axi_burst_writer_chk.sv
// Protocol checker for the writer's AXI master side: channel payloads held while stalled.
module axi_burst_writer_chk #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  awvalid,
  input logic                  awready,
  input logic [ADDR_WIDTH-1:0] awaddr,
  input logic [7:0]            awlen,
  input logic                  wvalid,
  input logic                  wready,
  input logic [DATA_WIDTH-1:0] wdata,
  input logic                  wlast,
  input logic                  bvalid,
  input logic                  bready,
  input logic [ID_WIDTH-1:0]   bid
);

  aw_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
    awvalid && !awready |=> awvalid && $stable(awaddr) && $stable(awlen));

  w_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
    wvalid && !wready |=> wvalid && $stable(wdata) && $stable(wlast));

  bid_match_c: cover property (@(posedge clk) disable iff (!rst_n)
    bvalid && bready && (bid == ID_WIDTH'(AXI_ID)));

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head word is visible on pop_data while not empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Overflow/underflow requests are dropped rather than corrupting the pointers.
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  assign full     = (count_r == (PW+1)'(DEPTH));
  assign empty    = (count_r == (PW+1)'(0));
  assign count    = count_r;
  assign pop_data = mem_r[rd_ptr_r];

  // Storage array, written on accepted push.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= (PW+1)'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/axi_burst_writer.sv
// AXI4 write master: buffers a valid/ready stream and writes it out as INCR bursts,
// splitting at MAX_BURST beats and at 4KB page boundaries, one burst outstanding.
module axi_burst_writer
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 0,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [LEN_WIDTH-1:0]    total_beats,
  input  logic                    s_valid,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    s_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ID_WIDTH-1:0]     awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp,
  input  logic [ID_WIDTH-1:0]     bid
);

  localparam int          BYTES    = DATA_WIDTH / 8;
  localparam int          ADDR_LSB = $clog2(BYTES);
  localparam int          CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [8:0]  MAX_BLEN = 9'(MAX_BURST);

  wr_state_e              state_r;
  wr_state_e              state_s;
  logic [ADDR_WIDTH-1:0]  addr_r;
  logic [LEN_WIDTH-1:0]   remaining_r;
  logic [8:0]             blen_r;
  logic [8:0]             beat_cnt_r;
  logic                   awvalid_r;
  logic [ADDR_WIDTH-1:0]  awaddr_r;
  logic [7:0]             awlen_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   error_r;

  logic [8:0]             rem_cap_s;
  logic [12:0]            page_room_s;
  logic [12:0]            page_beats_s;
  logic [8:0]             blen_s;
  logic                   in_data_s;
  logic                   w_last_s;

  logic                   fifo_push_s;
  logic                   fifo_pop_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [CNT_W-1:0]       fifo_count_s;
  logic [DATA_WIDTH-1:0]  fifo_head_s;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push_s),
    .push_data (s_data),
    .pop       (fifo_pop_s),
    .pop_data  (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  axi_burst_writer_chk #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ID_WIDTH   (ID_WIDTH),
    .AXI_ID     (AXI_ID)
  ) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .awvalid (awvalid),
    .awready (awready),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .wvalid  (wvalid),
    .wready  (wready),
    .wdata   (wdata),
    .wlast   (wlast),
    .bvalid  (bvalid),
    .bready  (bready),
    .bid     (bid)
  );

  // Next burst length: the smallest of what is left, the burst cap and the room left in the 4KB page.
  always_comb begin
    rem_cap_s    = MAX_BLEN;
    page_room_s  = 13'd4096 - {1'b0, addr_r[11:0]};
    page_beats_s = page_room_s >> ADDR_LSB;
    if (remaining_r < LEN_WIDTH'(MAX_BURST)) begin
      rem_cap_s = remaining_r[8:0];
    end else begin
      rem_cap_s = MAX_BLEN;
    end
    if (page_beats_s < {4'd0, rem_cap_s}) begin
      blen_s = page_beats_s[8:0];
    end else begin
      blen_s = rem_cap_s;
    end
  end

  assign s_ready     = busy_r && !fifo_full_s;
  assign fifo_push_s = s_valid && s_ready;
  assign in_data_s   = (state_r == WR_DATA);
  assign w_last_s    = (beat_cnt_r == (blen_r - 9'd1));
  assign wvalid      = in_data_s && !fifo_empty_s;
  assign wlast       = wvalid && w_last_s;
  assign wdata       = in_data_s ? fifo_head_s : {DATA_WIDTH{1'b0}};
  assign fifo_pop_s  = wvalid && wready;
  assign bready      = (state_r == WR_RESP);

  // Constant AW attributes are only driven during a job so the idle bus reads all-zero.
  assign awid    = busy_r ? ID_WIDTH'(AXI_ID) : {ID_WIDTH{1'b0}};
  assign awsize  = busy_r ? 3'(ADDR_LSB)      : 3'd0;
  assign awburst = busy_r ? AXI_BURST_INCR    : 2'b00;
  assign wstrb   = busy_r ? {BYTES{1'b1}}     : {BYTES{1'b0}};

  assign awvalid = awvalid_r;
  assign awaddr  = awaddr_r;
  assign awlen   = awlen_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign error   = error_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= WR_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; AW is only raised once the whole burst is already buffered.
  always_comb begin
    state_s = state_r;
    case (state_r)
      WR_IDLE: begin
        if (start) begin
          state_s = (total_beats == LEN_WIDTH'(0)) ? WR_DONE : WR_WAIT_DATA;
        end else begin
          state_s = WR_IDLE;
        end
      end
      WR_WAIT_DATA: begin
        if (32'(fifo_count_s) >= 32'(blen_s)) begin
          state_s = WR_ADDR;
        end else begin
          state_s = WR_WAIT_DATA;
        end
      end
      WR_ADDR: begin
        if (awready) begin
          state_s = WR_DATA;
        end else begin
          state_s = WR_ADDR;
        end
      end
      WR_DATA: begin
        if (fifo_pop_s && w_last_s) begin
          state_s = WR_RESP;
        end else begin
          state_s = WR_DATA;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          state_s = (remaining_r == LEN_WIDTH'(blen_r)) ? WR_DONE : WR_WAIT_DATA;
        end else begin
          state_s = WR_RESP;
        end
      end
      WR_DONE: state_s = WR_IDLE;
      default: state_s = WR_IDLE;
    endcase
  end

  // Job counters, AW registers and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r      <= {ADDR_WIDTH{1'b0}};
      remaining_r <= {LEN_WIDTH{1'b0}};
      blen_r      <= 9'd0;
      beat_cnt_r  <= 9'd0;
      awvalid_r   <= 1'b0;
      awaddr_r    <= {ADDR_WIDTH{1'b0}};
      awlen_r     <= 8'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      done_r <= (state_r == WR_DONE);
      busy_r <= (state_s inside {WR_WAIT_DATA, WR_ADDR, WR_DATA, WR_RESP});
      case (state_r)
        WR_IDLE: begin
          if (start) begin
            addr_r      <= base_addr & ~ADDR_WIDTH'(BYTES - 1);
            remaining_r <= total_beats;
            error_r     <= 1'b0;
          end
        end
        WR_WAIT_DATA: begin
          if (state_s == WR_ADDR) begin
            blen_r     <= blen_s;
            awaddr_r   <= addr_r;
            awlen_r    <= 8'(blen_s - 9'd1);
            awvalid_r  <= 1'b1;
            beat_cnt_r <= 9'd0;
          end
        end
        WR_ADDR: begin
          if (awready) begin
            awvalid_r <= 1'b0;
          end
        end
        WR_DATA: begin
          if (fifo_pop_s) begin
            beat_cnt_r <= beat_cnt_r + 9'd1;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            if (bresp != AXI_RESP_OKAY) begin
              error_r <= 1'b1;
            end
            addr_r      <= addr_r + (ADDR_WIDTH'(blen_r) << ADDR_LSB);
            remaining_r <= remaining_r - LEN_WIDTH'(blen_r);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
